// File: rtl/acc_bank.sv
// Multi-channel accumulator bank: NCH WIDTH-bit accumulators share one adder/subtractor.
// Each accepted op registers its result, carry/borrow and overflow with one cycle of latency.
module acc_bank #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [CHW-1:0]   ch,
    input  logic [WIDTH-1:0] accin,
    input  logic             cin,
    output logic             out_valid,
    output logic [CHW-1:0]   out_ch,
    output logic [WIDTH-1:0] account,
    output logic             cout,
    output logic             ovf,
    output logic [NCH-1:0]   sticky_ovf
);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_READ = 2'b11
    } op_t;

    op_t              op_sel;
    logic [WIDTH-1:0] acc [NCH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [NCH-1:0]   hit;
    logic             in_range;
    logic             c_out;
    logic             ov;
    logic             wr;

    assign op_sel = op_t'(op);

    always_comb begin
        cur = '0;
        hit = '0;
        // One-hot decode keeps out-of-range channels from ever indexing the array
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch == CHW'(i)) begin
                hit[i] = 1'b1;
                cur    = acc[i];
            end
        end
        in_range = |hit;

        sum  = {1'b0, cur} + {1'b0, accin} + {{WIDTH{1'b0}}, cin};
        diff = {1'b0, cur} - {1'b0, accin} - {{WIDTH{1'b0}}, cin};

        res   = cur;
        nxt   = cur;
        c_out = 1'b0;
        ov    = 1'b0;
        wr    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                c_out = sum[WIDTH];
                ov    = (cur[WIDTH-1] == accin[WIDTH-1]) && (res[WIDTH-1] != cur[WIDTH-1]);
                nxt   = (SAT != 0 && c_out) ? '1 : res;
                wr    = 1'b1;
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                c_out = diff[WIDTH];
                ov    = (cur[WIDTH-1] != accin[WIDTH-1]) && (res[WIDTH-1] != cur[WIDTH-1]);
                nxt   = (SAT != 0 && c_out) ? '0 : res;
                wr    = 1'b1;
            end
            OP_LOAD: begin
                nxt = accin;
                wr  = 1'b1;
            end
            default: nxt = cur;
        endcase

        if (!in_range) begin
            nxt   = '0;
            c_out = 1'b0;
            ov    = 1'b0;
            wr    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            account    <= '0;
            cout       <= 1'b0;
            ovf        <= 1'b0;
            sticky_ovf <= '0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            out_ch    <= ch;
            account   <= nxt;
            cout      <= c_out;
            ovf       <= ov;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (hit[i]) begin
                    if (wr) acc[i] <= nxt;
                    if (op_sel == OP_LOAD) sticky_ovf[i] <= 1'b0;
                    else if (ov)          sticky_ovf[i] <= 1'b1;
                end
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: a wrap-around and a saturating instance share stimulus; a reference
// model pushes expected registered outputs into a queue that is popped one cycle later.
module tb_acc_bank;

    typedef struct packed {
        logic       v;
        logic [2:0] ch;
        logic [7:0] acc;
        logic       co;
        logic       ov;
        logic [3:0] st;
    } exp_t;

    logic       clk = 1'b0;
    logic       clear, in_valid, cin;
    logic [1:0] op;
    logic [2:0] ch;
    logic [7:0] accin;

    logic       valid0, valid1, cout0, cout1, ovf0, ovf1;
    logic [2:0] och0, och1;
    logic [7:0] acc0, acc1;
    logic [3:0] sticky0, sticky1;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t last[2];
    int   macc[2][4];
    logic [3:0] mst[2];

    always #5 clk = ~clk;

    acc_bank #(.WIDTH(8), .NCH(4), .CHW(3), .SAT(0)) u_wrap (
        .clk(clk), .clear(clear), .in_valid(in_valid), .op(op), .ch(ch), .accin(accin), .cin(cin),
        .out_valid(valid0), .out_ch(och0), .account(acc0), .cout(cout0), .ovf(ovf0), .sticky_ovf(sticky0)
    );

    acc_bank #(.WIDTH(8), .NCH(4), .CHW(3), .SAT(1)) u_sat (
        .clk(clk), .clear(clear), .in_valid(in_valid), .op(op), .ch(ch), .accin(accin), .cin(cin),
        .out_valid(valid1), .out_ch(och1), .account(acc1), .cout(cout1), .ovf(ovf1), .sticky_ovf(sticky1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written from the arithmetic definition using integers
    task automatic model(input int d, input bit sat);
        exp_t e;
        int a, b, s, r;
        bit c, o;
        e = last[d];
        if (clear) begin
            for (int i = 0; i < 4; i++) macc[d][i] = 0;
            mst[d] = '0;
            e = '0;
        end else if (!in_valid) begin
            e.v = 1'b0;
        end else begin
            e.v = 1'b1;
            e.ch = ch;
            e.acc = '0;
            e.co = 1'b0;
            e.ov = 1'b0;
            if (ch < 3'd4) begin
                a = macc[d][ch];
                b = int'(accin);
                c = 1'b0;
                o = 1'b0;
                case (op)
                    2'd0: begin
                        s = a + b + int'(cin);
                        c = (s > 255);
                        r = s % 256;
                        o = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
                        if (sat && c) r = 255;
                    end
                    2'd1: begin
                        s = a - b - int'(cin);
                        c = (s < 0);
                        r = c ? s + 256 : s;
                        o = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
                        if (sat && c) r = 0;
                    end
                    2'd2: begin
                        r = b;
                        mst[d][ch] = 1'b0;
                    end
                    default: r = a;
                endcase
                if (op != 2'd3) macc[d][ch] = r;
                if (o) mst[d][ch] = 1'b1;
                e.acc = 8'(r);
                e.co = c;
                e.ov = o;
            end
        end
        e.st = mst[d];
        last[d] = e;
        q.push_back(e);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic v, input logic [2:0] oc,
                           input logic [7:0] a, input logic co, input logic ov, input logic [3:0] st);
        chk({tag, ".valid"}, 32'(v), 32'(e.v));
        chk({tag, ".ch"}, 32'(oc), 32'(e.ch));
        chk({tag, ".account"}, 32'(a), 32'(e.acc));
        chk({tag, ".cout"}, 32'(co), 32'(e.co));
        chk({tag, ".ovf"}, 32'(ov), 32'(e.ov));
        chk({tag, ".sticky"}, 32'(st), 32'(e.st));
    endtask

    task automatic step(input bit clr, input bit v, input logic [1:0] o, input logic [2:0] c,
                        input logic [7:0] a, input bit ci);
        exp_t e0, e1;
        clear = clr; in_valid = v; op = o; ch = c; accin = a; cin = ci;
        model(0, 1'b0);
        model(1, 1'b1);
        @(posedge clk);
        #1;
        if (q.size() < 2) begin
            chk("scoreboard_depth", 32'(q.size()), 32'd2);
        end else begin
            e0 = q.pop_front();
            e1 = q.pop_front();
            compare("wrap", e0, valid0, och0, acc0, cout0, ovf0, sticky0);
            compare("sat", e1, valid1, och1, acc1, cout1, ovf1, sticky1);
        end
        in_valid = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        clear = 1'b1; in_valid = 1'b0; op = 2'd0; ch = 3'd0; accin = 8'd0; cin = 1'b0;
        last[0] = '0; last[1] = '0;

        step(1, 0, 2'd0, 3'd0, 8'h00, 0);
        step(1, 0, 2'd0, 3'd0, 8'h00, 0);
        chk("reset_valid", 32'(valid0), 32'd0);
        chk("reset_sticky", 32'(sticky1), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'd3, 3'(i), 8'h00, 0);

        // Carry out of ADD: wrap vs saturate
        step(0, 1, 2'd2, 3'd1, 8'hF0, 0);
        step(0, 1, 2'd0, 3'd1, 8'h20, 0);
        chk("add_carry_wrap", 32'(acc0), 32'h10);
        chk("add_carry_sat", 32'(acc1), 32'hFF);
        chk("add_carry_cout", 32'(cout1), 32'd1);

        // Signed overflow and sticky flag
        step(0, 1, 2'd2, 3'd2, 8'h7F, 0);
        step(0, 1, 2'd0, 3'd2, 8'h01, 0);
        chk("ovf_acc", 32'(acc0), 32'h80);
        chk("ovf_flag", 32'(ovf0), 32'd1);
        chk("ovf_sticky", 32'(sticky0[2]), 32'd1);
        step(0, 1, 2'd2, 3'd2, 8'h00, 0);
        chk("sticky_load_clr", 32'(sticky0[2]), 32'd0);

        // Subtract with borrow-in, then underflow
        step(0, 1, 2'd2, 3'd0, 8'h05, 0);
        step(0, 1, 2'd1, 3'd0, 8'h03, 1);
        chk("sub_bin", 32'(acc0), 32'h01);
        step(0, 1, 2'd1, 3'd0, 8'h02, 0);
        chk("sub_borrow_wrap", 32'(acc0), 32'hFF);
        chk("sub_borrow_sat", 32'(acc1), 32'h00);
        chk("sub_borrow_cout", 32'(cout0), 32'd1);

        // Back-to-back adds on one channel, others untouched
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 2'd0, 3'd3, 8'h01, 0);
            chk("b2b_acc", 32'(acc0), 32'(i));
        end
        for (int i = 0; i < 3; i++) step(0, 1, 2'd3, 3'(i), 8'h00, 0);

        // Idle cycle holds outputs
        step(0, 0, 2'd0, 3'd0, 8'h55, 1);

        // Out-of-range channels
        for (int i = 4; i < 8; i++) step(0, 1, 2'(i), 3'(i), 8'hA5, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 2'd3, 3'(i), 8'h00, 0);

        // Clear wins over an op presented with it
        step(1, 1, 2'd0, 3'd3, 8'h11, 0);
        chk("clear_prio_valid", 32'(valid1), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'd3, 3'(i), 8'h00, 0);

        // Random mix, mostly valid ops, occasional clear and out-of-range channel
        for (int n = 0; n < 300; n++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 4)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
